// File: rtl/platform_pkg.sv
// rtl/platform_pkg.sv - shared types and geometry for the platform scroller and renderer
package platform_pkg;
  localparam int NUM_ROWS  = 31;
  localparam int COLS      = 3;
  localparam int ROW_PITCH = 30;
  localparam int SCREEN_H  = 600;
  localparam int Y_W       = 11;

  typedef logic signed [Y_W-1:0] row_y_t;
  typedef enum logic [1:0] {IDLE, SCROLL, RECYCLE} scroll_state_t;
endpackage

// File: rtl/platform_refill.sv
// rtl/platform_refill.sv - new activation for a recycled row; never lets four rows in a row be empty
module platform_refill #(
  parameter int COLS = 3
) (
  input  logic [COLS-1:0] rnd,
  input  logic [1:0]      empty_run,
  input  logic            recycle,
  output logic [COLS-1:0] new_act,
  output logic [1:0]      next_empty_run
);
  localparam logic [COLS-1:0] MID_SLOT = (COLS)'(1 << (COLS / 2));

  always_comb begin
    new_act        = rnd;
    next_empty_run = empty_run;
    if (recycle) begin
      if (rnd != '0) begin
        next_empty_run = 2'd0;
      end else if (empty_run == 2'd3) begin
        new_act        = MID_SLOT;
        next_empty_run = 2'd0;
      end else begin
        next_empty_run = empty_run + 2'd1;
      end
    end
  end
endmodule

// File: rtl/platform_scroller.sv
// rtl/platform_scroller.sv - scrolls a ring of platform rows down the screen after each jump
// and refills rows that fall off the bottom, one row per cycle.
module platform_scroller #(
  parameter int NUM_ROWS      = 31,
  parameter int COLS          = 3,
  parameter int ROW_PITCH     = 30,
  parameter int TOP_Y         = -162,
  parameter int SCREEN_H      = 600,
  parameter int SCROLL_STEP   = 12,
  parameter int SCROLL_FRAMES = 16,
  parameter logic [NUM_ROWS*COLS-1:0] INIT_ACT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 jump_trigger,
  input  logic [15:0]          rnd,
  output platform_pkg::row_y_t row_y   [NUM_ROWS],
  output logic [COLS-1:0]      row_act [NUM_ROWS],
  output logic                 busy,
  output logic [15:0]          height
);
  import platform_pkg::row_y_t;
  import platform_pkg::scroll_state_t;
  import platform_pkg::IDLE;
  import platform_pkg::SCROLL;
  import platform_pkg::RECYCLE;

  localparam int          IDX_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int          FL_W       = $clog2(SCROLL_FRAMES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);
  localparam row_y_t      RING_Y     = row_y_t'(NUM_ROWS * ROW_PITCH);
  localparam row_y_t      STEP_Y     = row_y_t'(SCROLL_STEP);
  localparam row_y_t      LIMIT_Y    = row_y_t'(SCREEN_H);
  localparam logic [15:0] STEP_H     = 16'(SCROLL_STEP);
  localparam logic [15:0] HEIGHT_SAT = 16'hFFFF - STEP_H;

  scroll_state_t    state;
  logic [FL_W-1:0]  frames_left;
  logic             tick_pending;
  logic [1:0]       empty_run;
  logic [IDX_W-1:0] scan_idx;
  logic             recycle;
  logic [COLS-1:0]  new_act;
  logic [1:0]       next_empty_run;
  logic             unused_rnd;

  assign unused_rnd = ^rnd[15:COLS];
  assign recycle    = (state == RECYCLE) && (row_y[scan_idx] >= LIMIT_Y);

  platform_refill #(.COLS(COLS)) u_refill (
    .rnd            (rnd[COLS-1:0]),
    .empty_run      (empty_run),
    .recycle        (recycle),
    .new_act        (new_act),
    .next_empty_run (next_empty_run)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      frames_left  <= '0;
      tick_pending <= 1'b0;
      empty_run    <= 2'd0;
      scan_idx     <= '0;
      height       <= 16'd0;
      busy         <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_y[r]   <= row_y_t'(TOP_Y + r * ROW_PITCH);
        row_act[r] <= INIT_ACT[r*COLS +: COLS];
      end
    end else begin
      case (state)
        IDLE: begin
          // A tick coinciding with the jump is deliberately dropped.
          if (jump_trigger) begin
            frames_left <= FL_W'(SCROLL_FRAMES);
            state       <= SCROLL;
            busy        <= 1'b1;
          end
        end
        SCROLL: begin
          if (frame_tick || tick_pending) begin
            for (int r = 0; r < NUM_ROWS; r++) row_y[r] <= row_y[r] + STEP_Y;
            frames_left  <= jump_trigger ? FL_W'(SCROLL_FRAMES - 1) : frames_left - FL_W'(1);
            height       <= (height > HEIGHT_SAT) ? 16'hFFFF : height + STEP_H;
            tick_pending <= 1'b0;
            scan_idx     <= '0;
            state        <= RECYCLE;
          end else if (jump_trigger) begin
            frames_left <= FL_W'(SCROLL_FRAMES);
          end
        end
        RECYCLE: begin
          if (frame_tick)   tick_pending <= 1'b1;
          if (jump_trigger) frames_left  <= FL_W'(SCROLL_FRAMES);
          if (recycle) begin
            row_y[scan_idx]   <= row_y[scan_idx] - RING_Y;
            row_act[scan_idx] <= new_act;
            empty_run         <= next_empty_run;
          end
          if (scan_idx == LAST_IDX) begin
            if (frames_left != '0 || jump_trigger) begin
              state <= SCROLL;
            end else begin
              // A tick left over from the final scan must not start the next jump early.
              state        <= IDLE;
              busy         <= 1'b0;
              tick_pending <= 1'b0;
            end
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_platform_scroller.sv
// tb/tb_platform_scroller.sv - directed bench for platform_scroller
module tb_platform_scroller;
  localparam logic [92:0] INIT_PAT = {31{3'b101}};

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_tick = 1'b0;
  logic               jump_trigger = 1'b0;
  logic [15:0]        rnd = 16'd0;
  logic signed [10:0] row_y   [31];
  logic [2:0]         row_act [31];
  logic               busy;
  logic [15:0]        height;

  int checks = 0;
  int errors = 0;
  bit jumped;

  platform_scroller #(.INIT_ACT(INIT_PAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .jump_trigger (jump_trigger),
    .rnd          (rnd),
    .row_y        (row_y),
    .row_act      (row_act),
    .busy         (busy),
    .height       (height)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic t, input logic j);
    frame_tick   = t;
    jump_trigger = j;
    cyc(1);
    frame_tick   = 1'b0;
    jump_trigger = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    // Reset values
    do_reset();
    cyc(2);
    check_eq("rst_y0", row_y[0], -162);
    check_eq("rst_y30", row_y[30], 738);
    check_eq("rst_act0", row_act[0], 5);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_height", height, 0);

    // First step with rnd=0: rows 25..30 recycle, fourth empty forced to middle slot
    rnd = 16'h0000;
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    cyc(35);
    check_eq("s1_y24", row_y[24], 570);
    check_eq("s1_act24", row_act[24], 5);
    check_eq("s1_y25", row_y[25], -330);
    check_eq("s1_act25", row_act[25], 0);
    check_eq("s1_act26", row_act[26], 0);
    check_eq("s1_act27", row_act[27], 0);
    check_eq("s1_act28", row_act[28], 2);
    check_eq("s1_act29", row_act[29], 0);
    check_eq("s1_act30", row_act[30], 0);
    check_eq("s1_y30", row_y[30], -180);
    check_eq("s1_busy", busy, 1);
    check_eq("s1_height", height, 12);

    // Remaining 15 steps with rnd[2:0]=3
    rnd = 16'hA5A3;
    for (int i = 0; i < 15; i++) begin
      pulse(1'b1, 1'b0);
      cyc(35);
    end
    check_eq("full_y0", row_y[0], 30);
    check_eq("full_y20", row_y[20], -300);
    check_eq("full_act20", row_act[20], 3);
    check_eq("full_y24", row_y[24], -180);
    check_eq("full_act24", row_act[24], 3);
    check_eq("full_y25", row_y[25], -150);
    check_eq("full_y30", row_y[30], 0);
    check_eq("full_act30", row_act[30], 0);
    check_eq("full_height", height, 192);
    check_eq("full_busy", busy, 0);

    // Fast ticks (some land in RECYCLE) plus a retrigger after step 10
    do_reset();
    pulse(1'b0, 1'b1);
    jumped = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      frame_tick   = (c % 20 == 0);
      jump_trigger = (!jumped && height == 16'd120);
      if (jump_trigger) jumped = 1'b1;
      cyc(1);
      frame_tick   = 1'b0;
      jump_trigger = 1'b0;
      if (jumped && !busy) break;
    end
    check_eq("rt_jumped", int'(jumped), 1);
    check_eq("rt_busy", busy, 0);
    check_eq("rt_height", height, 312);
    check_eq("rt_y0", row_y[0], 150);
    check_eq("rt_y30", row_y[30], 120);

    // Coincident tick and jump in IDLE, then in SCROLL
    do_reset();
    pulse(1'b1, 1'b1);
    cyc(3);
    check_eq("co_idle_height", height, 0);
    check_eq("co_idle_busy", busy, 1);
    pulse(1'b1, 1'b1);
    check_eq("co_scroll_height", height, 12);
    check_eq("co_scroll_frames", int'(dut.frames_left), 15);

    // Reset in the middle of a scan
    do_reset();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    cyc(15);
    rst = 1'b0;
    cyc(1);
    check_eq("mid_y0", row_y[0], -162);
    check_eq("mid_y30", row_y[30], 738);
    check_eq("mid_act25", row_act[25], 5);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_height", height, 0);
    rst = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
